half_alt_div: RTL and testbench



---
 rtl/half_alt_div_if.sv | 37 +++
 rtl/half_alt_div.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_half_alt_div.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/half_alt_div_if.sv
// ---------------------------------------------------------------------------
// half_alt_div_if
//
// Request/response bundle for the iterative half-format divider.
//   start : request strobe, sampled by the divider only while busy is low
//   a, b  : dividend / divisor words {exp[5:0], mant[9:0]}
//   busy  : divider has an operation in flight
//   done  : one-cycle completion pulse
//   quot  : result word {exp[5:0], mant[9:0]}, held until the next done
//   ovf   : exponent overflow, quot saturated to 16'hFFFF
//   unf   : exponent underflow, quot flushed to 16'h0000
//   dz    : divide by zero, quot forced to 16'hFFFF
//
// master : the requester (drives start/a/b)
// slave  : the divider   (drives busy/done/quot/flags)
// ---------------------------------------------------------------------------
interface half_alt_div_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic        ovf;
    logic        unf;
    logic        dz;

    modport master (
        output start, a, b,
        input  busy, done, quot, ovf, unf, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, quot, ovf, unf, dz
    );
endinterface

// File: rtl/half_alt_div.sv
// ---------------------------------------------------------------------------
// half_alt_div
//
// Iterative unsigned divider for the 16-bit half format {exp[5:0], mant[9:0]},
// value = (mant/1024) * 2^(exp-31), no sign bit. A word with mant==0 is zero.
//
// Flow: IDLE captures the operands, NORM shifts unnormalised mantissas left
// one bit per cycle, DIV runs a restoring divider (one quotient bit per
// cycle), PACK assembles the result, applies overflow/underflow and raises
// done for one cycle.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; aborts any operation in flight
//   bus   : half_alt_div_if.slave (start, a, b, busy, done, quot, ovf, unf, dz)
//
// Build option:
//   HALF_ALT_DIV_ROUND_EN : when defined, DIV produces one extra guard bit
//                           and the mantissa is rounded half up (one extra
//                           cycle of latency). Undefined: truncation.
// ---------------------------------------------------------------------------
module half_alt_div (
    input  logic          clk,
    input  logic          rst_n,
    half_alt_div_if.slave bus
);

`ifdef HALF_ALT_DIV_ROUND_EN
    localparam int DIV_ITERS = 12;
`else
    localparam int DIV_ITERS = 11;
`endif

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DIV,
        PACK
    } state_t;

    // What PACK has to emit: a computed quotient or one of the special cases
    // decided already at capture time.
    typedef enum logic [1:0] {
        KIND_FINITE,
        KIND_ZERO,
        KIND_DZ
    } kind_t;

    state_t                 state;
    state_t                 state_next;
    kind_t                  kind;

    logic [9:0]             ma;
    logic [9:0]             mb;
    logic signed [8:0]      ea;
    logic signed [8:0]      eb;
    logic [10:0]            rem;
    logic [DIV_ITERS-1:0]   q;
    logic [3:0]             iter;

    logic                   done_r;
    logic [15:0]            quot_r;
    logic                   ovf_r;
    logic                   unf_r;
    logic                   dz_r;

    // -----------------------------------------------------------------------
    // Restoring division step. rem < 2*mb holds throughout, so after a
    // successful subtract the difference fits in 10 bits, and when no
    // subtract happens rem < mb < 1024 so bit 10 is already zero.
    // -----------------------------------------------------------------------
    logic       rem_ge;
    logic [9:0] rem_diff;
    logic [9:0] rem_sel;

    assign rem_ge   = (rem >= {1'b0, mb});
    assign rem_diff = 10'(rem - {1'b0, mb});
    assign rem_sel  = rem_ge ? rem_diff : rem[9:0];

    // -----------------------------------------------------------------------
    // Result assembly from the finished quotient.
    // Non-rounding: q = floor(ma*1024/mb) in [512, 2046].
    // Rounding:     q = floor(ma*2048/mb), one guard bit below the LSB.
    // -----------------------------------------------------------------------
    logic signed [8:0] e_pack;
    logic [9:0]        mant_pack;

`ifdef HALF_ALT_DIV_ROUND_EN
    logic [9:0]  mant_trunc;
    logic        guard;
    logic [10:0] mant_round;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        e_pack     = ea - eb + 9'sd31;
        mant_trunc = q[10:1];
        guard      = q[0];
        mant_pack  = '0;
        if (q[11]) begin
            mant_trunc = q[11:2];
            guard      = q[1];
            e_pack     = e_pack + 9'sd1;
        end
        mant_round = {1'b0, mant_trunc} + {10'd0, guard};
        // Carry out of 1023 renormalises to 512 one binade up.
        if (mant_round[10]) begin
            mant_pack = 10'h200;
            e_pack    = e_pack + 9'sd1;
        end else begin
            mant_pack = mant_round[9:0];
        end
    end
`else
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        e_pack    = ea - eb + 9'sd31;
        mant_pack = q[9:0];
        if (q[10]) begin
            mant_pack = q[10:1];
            e_pack    = e_pack + 9'sd1;
        end
    end
`endif

    logic [15:0] quot_next;
    logic        ovf_next;
    logic        unf_next;
    logic        dz_next;

    always_comb begin
        quot_next = 16'h0000;
        ovf_next  = 1'b0;
        unf_next  = 1'b0;
        dz_next   = 1'b0;
        case (kind)
            KIND_DZ: begin
                quot_next = 16'hFFFF;
                dz_next   = 1'b1;
            end
            KIND_ZERO: begin
                quot_next = 16'h0000;
            end
            default: begin
                if (e_pack > 9'sd63) begin
                    quot_next = 16'hFFFF;
                    ovf_next  = 1'b1;
                end else if (e_pack < 9'sd0) begin
                    quot_next = 16'h0000;
                    unf_next  = 1'b1;
                end else begin
                    quot_next = {e_pack[5:0], mant_pack};
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.b[9:0] == 10'd0) || (bus.a[9:0] == 10'd0)) begin
                        state_next = PACK;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                if (ma[9] && mb[9]) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (iter == 4'(DIV_ITERS - 1)) begin
                    state_next = PACK;
                end
            end
            PACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: the datapath registers are reset along with the control state so
    // that an aborted operation leaves nothing behind and simulation never
    // starts from X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind   <= KIND_FINITE;
            ma     <= '0;
            mb     <= '0;
            ea     <= '0;
            eb     <= '0;
            rem    <= '0;
            q      <= '0;
            iter   <= '0;
            done_r <= 1'b0;
            quot_r <= 16'h0000;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ma <= bus.a[9:0];
                        mb <= bus.b[9:0];
                        ea <= $signed({3'b000, bus.a[15:10]});
                        eb <= $signed({3'b000, bus.b[15:10]});
                        // Divide-by-zero wins over a zero dividend.
                        if (bus.b[9:0] == 10'd0) begin
                            kind <= KIND_DZ;
                        end else if (bus.a[9:0] == 10'd0) begin
                            kind <= KIND_ZERO;
                        end else begin
                            kind <= KIND_FINITE;
                        end
                    end
                end
                NORM: begin
                    if (!ma[9]) begin
                        ma <= {ma[8:0], 1'b0};
                        ea <= ea - 9'sd1;
                    end
                    if (!mb[9]) begin
                        mb <= {mb[8:0], 1'b0};
                        eb <= eb - 9'sd1;
                    end
                    if (ma[9] && mb[9]) begin
                        rem  <= {1'b0, ma};
                        q    <= '0;
                        iter <= '0;
                    end
                end
                DIV: begin
                    rem  <= {rem_sel, 1'b0};
                    q    <= {q[DIV_ITERS-2:0], rem_ge};
                    iter <= iter + 4'd1;
                end
                PACK: begin
                    done_r <= 1'b1;
                    quot_r <= quot_next;
                    ovf_r  <= ovf_next;
                    unf_r  <= unf_next;
                    dz_r   <= dz_next;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.quot = quot_r;
    assign bus.ovf  = ovf_r;
    assign bus.unf  = unf_r;
    assign bus.dz   = dz_r;

endmodule

// File: tb/tb_half_alt_div.sv
// ---------------------------------------------------------------------------
// tb_half_alt_div
//
// Self-checking bench for half_alt_div. Expected results come from a
// value-level model: operands are normalised with a plain loop, the quotient
// mantissa is an integer division of the real ratio scaled into [0.5, 1),
// and latency is derived from the larger normalisation shift count.
// Build with HALF_ALT_DIV_ROUND_EN defined to check the rounding variant.
// ---------------------------------------------------------------------------
module tb_half_alt_div;

    logic clk;
    logic rst_n;

    half_alt_div_if bus_if ();

    half_alt_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] last_quot;
    logic [2:0]  last_flags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: flags are {ovf, unf, dz}; lat is the done edge number.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [2:0] flags,
                                  output int lat);
        int ma, mb, ea, eb, na, nb, e, m, s;
        ma = int'(a[9:0]);
        mb = int'(b[9:0]);
        ea = int'(a[15:10]);
        eb = int'(b[15:10]);
        q     = 16'h0000;
        flags = 3'b000;
        lat   = 1;
        if (mb == 0) begin
            q     = 16'hFFFF;
            flags = 3'b001;
            return;
        end
        if (ma == 0) return;
        na = 0;
        while (ma < 512) begin ma = ma * 2; ea--; na++; end
        nb = 0;
        while (mb < 512) begin mb = mb * 2; eb--; nb++; end
        lat = ((na > nb) ? na : nb) + 13;
        // Ratio in [0.5, 2): scale by 2 when >= 1 so the mantissa is in [0.5, 1).
        s = (ma >= mb) ? 1 : 0;
        e = ea - eb + 31 + s;
`ifdef HALF_ALT_DIV_ROUND_EN
        lat++;
        m = ((ma * 2048) / (mb << s) + 1) / 2;
        if (m == 1024) begin m = 512; e++; end
`else
        m = (ma * 1024) / (mb << s);
`endif
        if (e > 63) begin
            q     = 16'hFFFF;
            flags = 3'b100;
        end else if (e < 0) begin
            q     = 16'h0000;
            flags = 3'b010;
        end else begin
            q = 16'(e * 1024 + m);
        end
    endfunction

    function automatic logic [15:0] rand_operand();
        logic [9:0] m;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      m = 10'd0;
        else if (sel <= 3) m = 10'($urandom_range(1, 100));
        else               m = 10'($urandom_range(512, 1023));
        return {6'($urandom_range(0, 63)), m};
    endfunction

    // Called #1 after a rising edge. Issues one request and checks the whole
    // response. poke > 0 pulses start (with a divide-by-zero request) during
    // the operation; it must be ignored.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input string tag, input int poke);
        logic [15:0] exp_q;
        logic [2:0]  exp_f;
        int          exp_lat;
        int          got;
        model(a, b, exp_q, exp_f, exp_lat);
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        got = -1;
        for (int k = 1; k <= 60; k++) begin
            if (poke > 0 && k - 1 == poke) begin
                bus_if.a     = 16'h7E00;
                bus_if.b     = 16'h7C00;
                bus_if.start = 1'b1;
            end
            if (poke > 0 && k - 1 == poke + 1) bus_if.start = 1'b0;
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) begin
                got = k;
                break;
            end
        end
        bus_if.start = 1'b0;
        check({tag, "_lat"},   32'(got), 32'(exp_lat));
        check({tag, "_quot"},  32'(bus_if.quot), 32'(exp_q));
        check({tag, "_flags"}, 32'({bus_if.ovf, bus_if.unf, bus_if.dz}), 32'(exp_f));
        check({tag, "_idle"},  32'(bus_if.busy), 32'd0);
        last_quot  = exp_q;
        last_flags = exp_f;
    endtask

    // Called #1 after a rising edge; counts done pulses over n edges.
    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a     = 16'h0000;
        bus_if.b     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(bus_if.busy), 32'd0);
        check("rst_done",  32'(bus_if.done), 32'd0);
        check("rst_quot",  32'(bus_if.quot), 32'd0);
        check("rst_flags", 32'({bus_if.ovf, bus_if.unf, bus_if.dz}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values
        do_op(16'h7E00, 16'h7E00, "unity", 0);
        @(posedge clk); #1;
        check("pulse_done", 32'(bus_if.done), 32'd0);
        check("hold_quot",  32'(bus_if.quot), 32'(last_quot));
        do_op(16'h7E00, 16'h7F00, "two_thirds", 0);
        do_op(16'h7C80, 16'h7E00, "norm_a2", 0);
        do_op(16'hFE00, 16'h0200, "ovf", 0);
        do_op(16'h0200, 16'hFE00, "unf", 0);
        do_op(16'h5A7C, 16'h7C00, "dz", 0);
        do_op(16'h0000, 16'h7E00, "zero_a", 0);
        do_op(16'h7C00, 16'h0400, "dz_prio", 0);
        do_op(16'h8001, 16'h7C40, "norm_both", 0);
        do_op(16'h7E00, 16'h7FFF, "min_q", 0);
        do_op(16'h7FFF, 16'h7E00, "max_q", 0);
        @(posedge clk); #1;
        check("flags_clear_hold", 32'({bus_if.ovf, bus_if.unf, bus_if.dz}), 32'(last_flags));

        // start pulsed while busy must be ignored and not queued
        do_op(16'h7E00, 16'h7F00, "ignore", 3);
        count_dones(16, n);
        check("ignore_nodone", 32'(n), 32'd0);

        // Back-to-back random requests (each start lands in the done cycle)
        for (int i = 0; i < 40; i++) begin
            do_op(rand_operand(), rand_operand(), "rand", 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check("rand_pulse", 32'(bus_if.done), 32'd0);
            end
        end

        // Reset mid-operation
        do_op(16'h7E00, 16'h7F00, "pre_abort", 0);
        bus_if.a     = 16'h7E00;
        bus_if.b     = 16'h7F00;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(bus_if.busy), 32'd0);
        check("abort_done",  32'(bus_if.done), 32'd0);
        check("abort_quot",  32'(bus_if.quot), 32'd0);
        check("abort_flags", 32'({bus_if.ovf, bus_if.unf, bus_if.dz}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_dones(20, n);
        check("abort_nodone", 32'(n), 32'd0);
        check("abort_quot_held", 32'(bus_if.quot), 32'd0);

        // Operation after abort works normally
        do_op(16'h7F00, 16'h7E00, "post_abort", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
